// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern-detect controller.
// Provides the run-state enum, default sizing/pattern and the length clamp.
package seq_det_pkg;

    localparam int          MAX_LEN_DEF     = 12;
    localparam logic [11:0] DEF_PATTERN_DEF = 12'b111000000111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HUNT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // A pattern shorter than 2 bits is meaningless; longer than the window
    // cannot be held. Clamp into [2, max_len].
    function automatic int unsigned clamp_len(int unsigned len,
                                              int unsigned max_len);
        if (len < 2) begin
            return 2;
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_window_match.sv
// Serial shift window, fill counter and masked pattern compare.
// Ports: clk, rst (async high), clr_i (restart), shift_i (accepted bit),
//   x_i (data), ovl_i (overlap), len_i, pattern_i; match_o and full_o are
//   combinational strobes describing the result of the current shift.
module seq_window_match
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = MAX_LEN_DEF,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic               x_i,
    input  logic               ovl_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    output logic               match_o,
    output logic               full_o
);

    // Only the newest MAX_LEN-1 bits are kept; together with the incoming
    // bit they form the full MAX_LEN window that is compared.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;

    logic [MAX_LEN-1:0] win_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_nxt;
    logic               hit;

    always_comb begin
        win_nxt = {hist_q, x_i};

        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_i));
        end

        fill_nxt = (fill_q < len_i) ? fill_q + LEN_W'(1) : len_i;

        hit = (((win_nxt ^ pattern_i) & mask) == '0)
              && (fill_nxt == len_i);

        match_o = shift_i && hit;
        full_o  = shift_i && (fill_nxt == len_i);

        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = win_nxt[MAX_LEN-2:0];
            // Non-overlapping mode: bits of a match are not reused.
            fill_d = (hit && !ovl_i) ? '0 : fill_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Runtime-configurable serial pattern-detect controller: config registers
// behind a valid/ready port, run FSM (IDLE/FILL/HUNT/DONE), match counter.
// Ports: clk, rst; cfg_valid_i/cfg_ready_o + cfg_pattern_i/len/ovl/target;
//   start_i, abort_i; x_valid_i, x_i; det_o, busy_o, done_o, match_cnt_o.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter  int                 MAX_LEN     = MAX_LEN_DEF,
    parameter  int                 CNT_W       = 8,
    parameter  logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_DEF),
    localparam int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_ovl_i,
    input  logic [CNT_W-1:0]   cfg_target_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               x_valid_i,
    input  logic               x_i,
    output logic               det_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   match_cnt_o
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               det_q, det_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic             idle_like;
    logic             running;
    logic             start_go;
    logic             shift;
    logic             match;
    logic             full;
    logic [CNT_W-1:0] cnt_inc;

    seq_window_match #(
        .MAX_LEN (MAX_LEN)
    ) u_win (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start_go),
        .shift_i   (shift),
        .x_i       (x_i),
        .ovl_i     (ovl_q),
        .len_i     (len_q),
        .pattern_i (pattern_q),
        .match_o   (match),
        .full_o    (full)
    );

    always_comb begin
        idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
        running   = (state_q == ST_FILL) || (state_q == ST_HUNT);
        start_go  = start_i && idle_like && !abort_i;
        // Abort suppresses the shift so a completing bit cannot pulse det_o.
        shift     = running && x_valid_i && !abort_i;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        pattern_d = pattern_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        target_d  = target_q;
        if (cfg_valid_i && idle_like) begin
            pattern_d = cfg_pattern_i;
            len_d     = LEN_W'(clamp_len(32'(cfg_len_i), MAX_LEN));
            ovl_d     = cfg_ovl_i;
            target_d  = cfg_target_i;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        det_d   = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                    end
                end
                ST_FILL, ST_HUNT: begin
                    if (match) begin
                        det_d = 1'b1;
                        cnt_d = cnt_inc;
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            state_d = ST_DONE;
                        end else if (!ovl_q) begin
                            state_d = ST_FILL;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end else if (full) begin
                        state_d = ST_HUNT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_FILL) || (state_d == ST_HUNT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(MAX_LEN);
            ovl_q     <= 1'b1;
            target_q  <= '0;
            cnt_q     <= '0;
            det_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            det_q     <= det_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cfg_ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign det_o       = det_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl (2-bit counter to reach saturation).
// Vector tables feed a scoreboard queue; corner cases are hand sequenced.
module tb_seq_det_ctrl;

    localparam int ML = 12;
    localparam int CW = 2;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [ML-1:0] cfg_pattern_i = '0;
    logic [LW-1:0] cfg_len_i = '0;
    logic          cfg_ovl_i = 1'b0;
    logic [CW-1:0] cfg_target_i = '0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          x_valid_i = 1'b0;
    logic          x_i = 1'b0;
    logic          det_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] match_cnt_o;

    seq_det_ctrl #(
        .MAX_LEN (ML),
        .CNT_W   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_pattern_i (cfg_pattern_i),
        .cfg_len_i     (cfg_len_i),
        .cfg_ovl_i     (cfg_ovl_i),
        .cfg_target_i  (cfg_target_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .x_valid_i     (x_valid_i),
        .x_i           (x_i),
        .det_o         (det_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .match_cnt_o   (match_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          xv;
        logic          x;
        logic          det;
        logic [CW-1:0] cnt;
        logic          busy;
        logic          done;
    } vec_t;

    typedef struct {
        logic          det;
        logic [CW-1:0] cnt;
        logic          busy;
        logic          done;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(logic xv, logic x, logic det, int cnt,
                                logic busy, logic done);
        tv.push_back('{xv, x, det, CW'(cnt), busy, done});
    endfunction

    task automatic run_vecs(string nm);
        exp_t e;
        for (int i = 0; i < tv.size(); i++) begin
            x_valid_i = tv[i].xv;
            x_i       = tv[i].x;
            sb.push_back('{tv[i].det, tv[i].cnt, tv[i].busy, tv[i].done});
            tick();
            e = sb.pop_front();
            chk($sformatf("%s[%0d].det", nm, i), 32'(det_o), 32'(e.det));
            chk($sformatf("%s[%0d].cnt", nm, i), 32'(match_cnt_o),
                32'(e.cnt));
            chk($sformatf("%s[%0d].busy", nm, i), 32'(busy_o), 32'(e.busy));
            chk($sformatf("%s[%0d].done", nm, i), 32'(done_o), 32'(e.done));
        end
        x_valid_i = 1'b0;
        x_i       = 1'b0;
        tv.delete();
    endtask

    task automatic do_cfg(logic [ML-1:0] pat, int len, logic ovl, int tgt);
        chk("cfg_ready_idle", 32'(cfg_ready_o), 32'd1);
        cfg_valid_i   = 1'b1;
        cfg_pattern_i = pat;
        cfg_len_i     = LW'(len);
        cfg_ovl_i     = ovl;
        cfg_target_i  = CW'(tgt);
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic start_run();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start.busy", 32'(busy_o), 32'd1);
        chk("start.cnt", 32'(match_cnt_o), 32'd0);
        chk("start.done", 32'(done_o), 32'd0);
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort.busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ML-1:0] p;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst.det", 32'(det_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.cnt", 32'(match_cnt_o), 32'd0);
        chk("rst.ready", 32'(cfg_ready_o), 32'd1);

        // Default pattern, FILL->HUNT and match on the same edge.
        start_run();
        p = 12'b111000000111;
        for (int i = ML - 1; i >= 0; i--) begin
            add(1, p[i], i == 0, (i == 0) ? 1 : 0, 1, 0);
        end
        add(1, 0, 0, 1, 1, 0);
        run_vecs("def");

        // 101 overlapping, then non-overlapping.
        do_abort();
        do_cfg(12'b101, 3, 1, 0);
        start_run();
        add(1, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 0);
        add(1, 1, 1, 2, 1, 0);
        run_vecs("ovl1");
        do_abort();
        do_cfg(12'b101, 3, 0, 0);
        start_run();
        add(1, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 1, 1, 0);
        run_vecs("ovl0");

        // Target reached, DONE ignores data, restart from DONE.
        do_abort();
        do_cfg(12'b11, 2, 1, 3);
        start_run();
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 1, 2, 1, 0);
        add(1, 1, 1, 3, 0, 1);
        add(1, 1, 0, 3, 0, 1);
        add(1, 1, 0, 3, 0, 1);
        run_vecs("tgt");
        chk("done.ready", 32'(cfg_ready_o), 32'd1);
        start_run();

        // Gaps in x_valid_i hold the window.
        do_abort();
        do_cfg(12'b101, 3, 1, 0);
        start_run();
        add(1, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        run_vecs("gap");

        // Config write refused while hunting.
        cfg_valid_i   = 1'b1;
        cfg_pattern_i = 12'b111;
        cfg_len_i     = LW'(3);
        cfg_target_i  = CW'(1);
        chk("hunt.ready", 32'(cfg_ready_o), 32'd0);
        tick();
        cfg_valid_i = 1'b0;
        add(1, 0, 0, 1, 1, 0);
        add(1, 1, 1, 2, 1, 0);
        run_vecs("cfgbusy");

        // Abort on the completing bit.
        add(1, 0, 0, 2, 1, 0);
        run_vecs("preab");
        x_valid_i = 1'b1;
        x_i       = 1'b1;
        abort_i   = 1'b1;
        tick();
        abort_i   = 1'b0;
        x_valid_i = 1'b0;
        chk("abedge.det", 32'(det_o), 32'd0);
        chk("abedge.busy", 32'(busy_o), 32'd0);
        chk("abedge.cnt", 32'(match_cnt_o), 32'd2);
        chk("abedge.ready", 32'(cfg_ready_o), 32'd1);

        // Abort wins over start.
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("stab.busy", 32'(busy_o), 32'd0);
        chk("stab.cnt", 32'(match_cnt_o), 32'd2);

        // Asynchronous reset mid-run.
        start_run();
        add(1, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        run_vecs("prerst");
        #2;
        rst = 1'b1;
        #1;
        chk("arst.det", 32'(det_o), 32'd0);
        chk("arst.busy", 32'(busy_o), 32'd0);
        chk("arst.done", 32'(done_o), 32'd0);
        chk("arst.cnt", 32'(match_cnt_o), 32'd0);
        chk("arst.ready", 32'(cfg_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Length 0 behaves as 2; upper pattern bits ignored.
        do_cfg(12'hFFD, 0, 1, 0);
        start_run();
        add(1, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 0);
        add(1, 1, 1, 2, 1, 0);
        run_vecs("len0");

        // Length 15 behaves as 12.
        do_abort();
        do_cfg(12'b101100111000, 15, 0, 0);
        start_run();
        p = 12'b101100111000;
        for (int i = ML - 1; i >= 0; i--) begin
            add(1, p[i], i == 0, (i == 0) ? 1 : 0, 1, 0);
        end
        run_vecs("len15");

        // Counter saturates at 3.
        do_abort();
        do_cfg(12'b11, 2, 1, 0);
        start_run();
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 1, 2, 1, 0);
        add(1, 1, 1, 3, 1, 0);
        add(1, 1, 1, 3, 1, 0);
        add(1, 1, 1, 3, 1, 0);
        run_vecs("sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
